fetch_stage: RTL

Instruction fetch stage at the head of the five-stage pipeline. It owns the architectural PC, reads one instruction per cycle from a combinational instruction memory port, and fills the FE latch that the decode stage consumes. It honours the decode-stage stall and applies branch/jump redirects from the AGEX stage, inserting bubbles for wrong-path fetches.

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch at the head of the five-stage pipeline.
//
// Owns the architectural PC and drives it to a combinational instruction
// memory. Each cycle the returned word goes into the FE latch for decode,
// unless decode stalls or a branch/jump redirect arrives from AGEX.
//
// Per-cycle priority, highest first: reset, redirect, stall, advance.
// Redirects write an all-zero latch (a bubble), which throws away the
// wrong-path fetch. Decode treats inst == 0 as invalid, so there is no
// separate valid bit.
//
// Optional build macro: FE_PERF_CNT_EN builds the saturating stall/redirect
// counters. When it is undefined, both counter outputs are tied to 0.
// Pipeline behaviour is the same in both builds.
//
// Ports:
//   clk, reset        pipeline clock; synchronous active-high reset
//   from_DE_to_FE     [0] = de_stall
//   from_AGEX_to_FE   {br_redirect, br_target[`DBITS-1:0]}
//   imem_addr         fetch address (= PC)
//   imem_rdata        instruction word at imem_addr, same cycle
//   FE_latch_out      {inst, PC, pcplus, inst_count, bus_canary}
//   stall_cycles      stall-priority cycles (perf build)
//   redirect_count    redirects applied (perf build)

`ifndef DBITS
`define DBITS 32
`endif
`ifndef INSTBITS
`define INSTBITS 32
`endif
`ifndef BUS_CANARY_WIDTH
`define BUS_CANARY_WIDTH 4
`endif
`ifndef BUS_CANARY_VALUE
`define BUS_CANARY_VALUE 4'hF
`endif
`ifndef from_DE_to_FE_WIDTH
`define from_DE_to_FE_WIDTH 1
`endif
`ifndef from_AGEX_to_FE_WIDTH
`define from_AGEX_to_FE_WIDTH (`DBITS + 1)
`endif
`ifndef FE_latch_WIDTH
`define FE_latch_WIDTH (`INSTBITS + 3 * `DBITS + `BUS_CANARY_WIDTH)
`endif

module fetch_stage #(
  parameter logic [`DBITS-1:0] STARTPC       = '0,
  parameter int                PERF_CNT_BITS = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [`from_DE_to_FE_WIDTH-1:0]   from_DE_to_FE,
  input  logic [`from_AGEX_to_FE_WIDTH-1:0] from_AGEX_to_FE,
  output logic [`DBITS-1:0]                 imem_addr,
  input  logic [`INSTBITS-1:0]              imem_rdata,
  output logic [`FE_latch_WIDTH-1:0]        FE_latch_out,
  output logic [PERF_CNT_BITS-1:0]          stall_cycles,
  output logic [PERF_CNT_BITS-1:0]          redirect_count
);

  // Field layout of the FE latch, MSB first.
  typedef struct packed {
    logic [`INSTBITS-1:0]         inst;
    logic [`DBITS-1:0]            pc;
    logic [`DBITS-1:0]            pcplus;
    logic [`DBITS-1:0]            inst_count;
    logic [`BUS_CANARY_WIDTH-1:0] canary;
  } fe_latch_t;

  // Incoming control from decode and AGEX.
  typedef struct packed {
    logic              redirect;
    logic [`DBITS-1:0] target;
  } agex_req_t;

  localparam logic [`DBITS-1:0] PC_STEP  = `DBITS'(4);
  // Clear the low bits even if someone overrides STARTPC with a
  // misaligned value.
  localparam logic [`DBITS-1:0] PC_RESET = {STARTPC[`DBITS-1:2], 2'b00};

  logic      de_stall;
  agex_req_t agex;

  assign de_stall = from_DE_to_FE[0];
  assign agex     = agex_req_t'(from_AGEX_to_FE);

  // The target is forced word-aligned, so its low bits are ignored.
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^agex.target[1:0];

  // --------------------------------------------------------------------
  // Architectural state
  // --------------------------------------------------------------------
  logic [`DBITS-1:0] pc_q,    pc_d;
  logic [`DBITS-1:0] icnt_q,  icnt_d;
  fe_latch_t         latch_q, latch_d;
  logic [`DBITS-1:0] pcplus;

  // Natural modular add: PC 0xFFFF_FFFC yields pcplus 0.
  assign pcplus = pc_q + PC_STEP;

  always_comb begin
    pc_d    = pc_q;
    icnt_d  = icnt_q;
    latch_d = latch_q;
    if (agex.redirect) begin
      // A redirect wins over a stall. The latch currently holds a
      // wrong-path fetch, so it is replaced with a bubble.
      pc_d    = {agex.target[`DBITS-1:2], 2'b00};
      latch_d = '0;
    end else if (!de_stall) begin
      icnt_d         = icnt_q + `DBITS'(1);
      pc_d           = pcplus;
      latch_d.inst   = imem_rdata;
      latch_d.pc     = pc_q;
      latch_d.pcplus = pcplus;
      // The new count goes into the latch, so the first instruction
      // after reset carries 1.
      latch_d.inst_count = icnt_d;
      latch_d.canary     = `BUS_CANARY_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      icnt_q  <= '0;
      latch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      icnt_q  <= icnt_d;
      latch_q <= latch_d;
    end
  end

  assign imem_addr    = pc_q;
  assign FE_latch_out = latch_q;

  // --------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------
`ifdef FE_PERF_CNT_EN
  logic [PERF_CNT_BITS-1:0] stall_q, stall_d;
  logic [PERF_CNT_BITS-1:0] redir_q, redir_d;

  // Both counters saturate at all-ones rather than wrapping.
  always_comb begin
    stall_d = stall_q;
    redir_d = redir_q;
    if (agex.redirect) begin
      if (~&redir_q) redir_d = redir_q + PERF_CNT_BITS'(1);
    end else if (de_stall) begin
      if (~&stall_q) stall_d = stall_q + PERF_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      stall_q <= stall_d;
      redir_q <= redir_d;
    end
  end

  assign stall_cycles   = stall_q;
  assign redirect_count = redir_q;
`else
  assign stall_cycles   = '0;
  assign redirect_count = '0;
`endif

endmodule
